// File: rtl/dyn_branch_predictor.sv
// dyn_branch_predictor: saturating-counter BHT plus tagged BTB with a sequential clear engine and
// mispredict stats; latency: lookup is combinational and an update is visible the cycle after upd_valid;
// backpressure: none, busy marks the ENTRIES-cycle clear (lookups miss, updates dropped). `define GSHARE_INDEX_EN for gshare indexing.
module dyn_branch_predictor #(
  parameter int ENTRIES = 8,
  parameter int PC_W    = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   IF_PC,
  output logic              hit,
  output logic              predict_taken,
  output logic [PC_W-1:0]   predicted_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_PC,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic              clear_req,
  output logic              busy,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 1;

  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_idx;
  logic [ENTRIES-1:0] valid;

  logic [TAG_W-1:0] tag_mem [ENTRIES];
  logic [CNT_W-1:0] cnt_mem [ENTRIES];
  logic [PC_W-1:0]  tgt_mem [ENTRIES];

  logic             in_idle;
  logic             clr_start;
  logic             upd_en;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lk_hit;
  logic             upd_match;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_nxt;
  logic             is_mispred;
  logic             unused_upd_pc_lsb;

  assign in_idle   = (state == ST_IDLE);
  assign clr_start = in_idle && clear_req;
  // A clear request in the same cycle as an update wins; the update is dropped.
  assign upd_en    = in_idle && upd_valid && !clear_req;

  assign lk_tag  = IF_PC[PC_W-1:IDX_W+1];
  assign upd_tag = upd_PC[PC_W-1:IDX_W+1];
  assign unused_upd_pc_lsb = upd_PC[0];

`ifdef GSHARE_INDEX_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else if (clr_start)
      ghr <= '0;
    else if (upd_en)
      ghr <= IDX_W'({ghr, upd_taken});
  end

  assign lk_idx  = IF_PC[IDX_W:1] ^ ghr;
  assign upd_idx = upd_PC[IDX_W:1] ^ ghr;
`else
  assign lk_idx  = IF_PC[IDX_W:1];
  assign upd_idx = upd_PC[IDX_W:1];
`endif

  assign cnt_cur    = cnt_mem[upd_idx];
  assign upd_match  = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign is_mispred = (upd_pred_taken != upd_taken);

  always_comb begin
    cnt_nxt = cnt_cur;
    if (upd_taken) begin
      if (cnt_cur != CNT_MAX)
        cnt_nxt = cnt_cur + 1'b1;
    end else if (cnt_cur != '0) begin
      cnt_nxt = cnt_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_CLEAR;
      clr_idx        <= '0;
      busy           <= 1'b1;
      valid          <= '0;
      mispredict_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          valid[clr_idx] <= 1'b0;
          clr_idx        <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(ENTRIES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state          <= ST_CLEAR;
            clr_idx        <= '0;
            busy           <= 1'b1;
            mispredict_cnt <= '0;
          end else if (upd_valid) begin
            valid[upd_idx] <= 1'b1;
            if (is_mispred && (mispredict_cnt != STAT_MAX))
              mispredict_cnt <= mispredict_cnt + 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Payload arrays carry no reset; the clear engine scrubs them after every reset.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      tag_mem[clr_idx] <= '0;
      cnt_mem[clr_idx] <= CNT_WNT;
      tgt_mem[clr_idx] <= '0;
    end else if (upd_en) begin
      if (upd_match) begin
        cnt_mem[upd_idx] <= cnt_nxt;
        if (upd_taken)
          tgt_mem[upd_idx] <= upd_target;
      end else begin
        tag_mem[upd_idx] <= upd_tag;
        cnt_mem[upd_idx] <= upd_taken ? CNT_WT : CNT_WNT;
        tgt_mem[upd_idx] <= upd_target;
      end
    end
  end

  assign lk_hit           = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign hit              = in_idle && lk_hit;
  assign predict_taken    = hit && cnt_mem[lk_idx][CNT_W-1];
  assign predicted_target = predict_taken ? tgt_mem[lk_idx] : IF_PC + PC_W'(2);

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Randomised and directed checks of dyn_branch_predictor against an entry-level reference model.
module tb_dyn_branch_predictor;

  localparam int E    = 8;
  localparam int PW   = 16;
  localparam int CW   = 2;
  localparam int SW   = 4;
  localparam int IW   = 3;
  localparam int WT   = 1 << (CW - 1);
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] IF_PC = '0;
  logic          hit;
  logic          predict_taken;
  logic [PW-1:0] predicted_target;
  logic          upd_valid = 1'b0;
  logic [PW-1:0] upd_PC = '0;
  logic          upd_taken = 1'b0;
  logic [PW-1:0] upd_target = '0;
  logic          upd_pred_taken = 1'b0;
  logic          clear_req = 1'b0;
  logic          busy;
  logic [SW-1:0] mispredict_cnt;

  always #5 clk = ~clk;

  dyn_branch_predictor #(.ENTRIES(E), .PC_W(PW), .CNT_W(CW), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .IF_PC(IF_PC), .hit(hit), .predict_taken(predict_taken),
    .predicted_target(predicted_target), .upd_valid(upd_valid), .upd_PC(upd_PC),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .clear_req(clear_req), .busy(busy), .mispredict_cnt(mispredict_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per entry, clear modelled as a countdown.
  bit m_valid [E];
  int m_tag   [E];
  int m_cnt   [E];
  int m_tgt   [E];
  int clr_left;
  int m_mis;
  int m_ghr;

  // Staged stimulus, applied to the DUT on the next falling edge.
  logic          s_rst_n = 1'b0;
  logic [PW-1:0] s_pc = '0;
  logic          s_uv = 1'b0;
  logic [PW-1:0] s_upc = '0;
  logic          s_ut = 1'b0;
  logic [PW-1:0] s_utgt = '0;
  logic          s_upt = 1'b0;
  logic          s_clr = 1'b0;

  function automatic void m_reset();
    clr_left = E;
    for (int i = 0; i < E; i++) m_valid[i] = 1'b0;
    m_mis = 0;
    m_ghr = 0;
  endfunction

  function automatic int idx_of(input int pc);
    int r;
    r = (pc >> 1) % E;
`ifdef GSHARE_INDEX_EN
    r = r ^ m_ghr;
`endif
    return r;
  endfunction

  function automatic int tag_of(input int pc);
    return pc >> (IW + 1);
  endfunction

  function automatic void m_step();
    int i;
    int tg;
    if (clr_left > 0) begin
      clr_left--;
    end else if (s_clr) begin
      clr_left = E;
      for (int k = 0; k < E; k++) m_valid[k] = 1'b0;
      m_mis = 0;
      m_ghr = 0;
    end else if (s_uv) begin
      i  = idx_of(int'(s_upc));
      tg = tag_of(int'(s_upc));
      if (m_valid[i] && m_tag[i] == tg) begin
        if (s_ut) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_tgt[i] = int'(s_utgt);
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tg;
        m_cnt[i]   = s_ut ? WT : WT - 1;
        m_tgt[i]   = int'(s_utgt);
      end
      if (s_upt != s_ut) m_mis = (m_mis < SMAX) ? m_mis + 1 : SMAX;
      m_ghr = ((m_ghr << 1) | int'(s_ut)) % E;
    end
  endfunction

  task automatic cycle();
    int i;
    int eh;
    int ept;
    int etgt;
    @(negedge clk);
    rst_n          = s_rst_n;
    IF_PC          = s_pc;
    upd_valid      = s_uv;
    upd_PC         = s_upc;
    upd_taken      = s_ut;
    upd_target     = s_utgt;
    upd_pred_taken = s_upt;
    clear_req      = s_clr;
    if (!s_rst_n) m_reset();
    #1;
    if (clr_left > 0) begin
      eh   = 0;
      ept  = 0;
      etgt = (int'(s_pc) + 2) & 16'hFFFF;
    end else begin
      i    = idx_of(int'(s_pc));
      eh   = (m_valid[i] && m_tag[i] == tag_of(int'(s_pc))) ? 1 : 0;
      ept  = (eh == 1 && m_cnt[i] >= WT) ? 1 : 0;
      etgt = (ept == 1) ? m_tgt[i] : (int'(s_pc) + 2) & 16'hFFFF;
    end
    check_val("busy", 32'(busy), (clr_left > 0) ? 32'd1 : 32'd0);
    check_val("hit", 32'(hit), eh);
    check_val("pred_taken", 32'(predict_taken), ept);
    check_val("pred_target", 32'(predicted_target), etgt);
    check_val("mis_cnt", 32'(mispredict_cnt), m_mis);
    if (s_rst_n) m_step();
  endtask

  task automatic set_upd(input logic [PW-1:0] pc, input logic t, input logic [PW-1:0] tgt,
                         input logic pt);
    s_uv   = 1'b1;
    s_upc  = pc;
    s_ut   = t;
    s_utgt = tgt;
    s_upt  = pt;
  endtask

  // Counts consecutive busy cycles (bounded); optionally pulses clear_req at one of them.
  task automatic count_busy(output int n, input int pulse_at);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      s_clr = (k == pulse_at);
      cycle();
      if (busy) n++;
      else break;
    end
    s_clr = 1'b0;
  endtask

  task automatic do_clear();
    int n;
    s_uv  = 1'b0;
    s_clr = 1'b1;
    cycle();
    s_clr = 1'b0;
    count_busy(n, -1);
    check_val("clear_len", n, E);
  endtask

  function automatic logic [PW-1:0] rand_pc();
    logic [11:0] tags [4];
    tags[0] = 12'h000;
    tags[1] = 12'h001;
    tags[2] = 12'h011;
    tags[3] = 12'hFFF;
    return {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    m_reset();
    s_pc = 16'h0010;
    repeat (3) cycle();

    s_rst_n = 1'b1;
    count_busy(n, -1);
    check_val("rst_clr_len", n, E);
    check_val("post_clr_hit", 32'(hit), 0);
    check_val("post_clr_tgt", 32'(predicted_target), 32'h0012);

`ifndef GSHARE_INDEX_EN
    set_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
    cycle();
    s_uv = 1'b0;
    cycle();
    check_val("alloc_hit", 32'(hit), 1);
    check_val("alloc_pt", 32'(predict_taken), 1);
    check_val("alloc_tgt", 32'(predicted_target), 32'h0040);
    set_upd(16'h0010, 1'b1, 16'h0040, 1'b1);
    repeat (2) cycle();
    set_upd(16'h0010, 1'b0, 16'h0040, 1'b1);
    repeat (3) cycle();
    s_uv = 1'b0;
    cycle();
    check_val("sat0_hit", 32'(hit), 1);
    check_val("sat0_pt", 32'(predict_taken), 0);
    check_val("sat0_tgt", 32'(predicted_target), 32'h0012);
    check_val("seq_mis", 32'(mispredict_cnt), 4);

    do_clear();
    set_upd(16'h0010, 1'b1, 16'h0040, 1'b1);
    cycle();
    set_upd(16'h0110, 1'b0, 16'h0080, 1'b0);
    cycle();
    s_uv = 1'b0;
    s_pc = 16'h0010;
    cycle();
    check_val("alias_old_hit", 32'(hit), 0);
    s_pc = 16'h0110;
    cycle();
    check_val("alias_new_hit", 32'(hit), 1);
    check_val("alias_new_pt", 32'(predict_taken), 0);
    check_val("alias_new_tgt", 32'(predicted_target), 32'h0112);
`else
    do_clear();
    set_upd(16'h0002, 1'b1, 16'h0030, 1'b1);
    cycle();
    set_upd(16'h0004, 1'b1, 16'h0034, 1'b1);
    cycle();
    s_uv = 1'b0;
    s_pc = 16'h0006;
    cycle();
    check_val("gs_0006_hit", 32'(hit), 0);
    s_pc = 16'h0000;
    cycle();
    check_val("gs_0000_hit", 32'(hit), 1);
    check_val("gs_0000_tgt", 32'(predicted_target), 32'h0034);
`endif

    do_clear();
    for (int k = 0; k < 5; k++) begin
      set_upd(16'(16'h0100 + 2 * k), 1'b1, 16'h0200, 1'b0);
      cycle();
    end
    s_uv = 1'b0;
    cycle();
    check_val("mis_five", 32'(mispredict_cnt), 5);
    for (int k = 0; k < 12; k++) begin
      set_upd(16'(16'h0300 + 2 * k), 1'b0, 16'h0200, 1'b1);
      cycle();
    end
    s_uv = 1'b0;
    cycle();
    check_val("mis_sat", 32'(mispredict_cnt), SMAX);

    set_upd(16'h0020, 1'b1, 16'h0050, 1'b0);
    s_clr = 1'b1;
    cycle();
    s_uv  = 1'b0;
    s_clr = 1'b0;
    count_busy(n, 3);
    check_val("clr_upd_len", n, E);
    check_val("clr_upd_mis", 32'(mispredict_cnt), 0);
    s_pc = 16'h0020;
    cycle();
    check_val("clr_upd_hit", 32'(hit), 0);

    s_clr = 1'b1;
    cycle();
    s_clr = 1'b0;
    repeat (4) cycle();
    s_rst_n = 1'b0;
    repeat (2) cycle();
    check_val("rst_mid_busy", 32'(busy), 1);
    s_rst_n = 1'b1;
    count_busy(n, -1);
    check_val("rst_mid_len", n, E);

    for (int c = 0; c < 3000; c++) begin
      logic [PW-1:0] prev_upc;
      prev_upc = s_upc;
      s_rst_n  = ($urandom_range(0, 599) != 0);
      s_clr    = ($urandom_range(0, 63) == 0);
      s_uv     = ($urandom_range(0, 3) != 0);
      s_upc    = rand_pc();
      s_ut     = 1'($urandom_range(0, 1));
      s_utgt   = 16'($urandom);
      s_upt    = 1'($urandom_range(0, 1));
      s_pc     = ($urandom_range(0, 1) == 1) ? prev_upc : rand_pc();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dyn_branch_predictor.md
Name: dyn_branch_predictor

Overview:
Parametrised dynamic branch predictor for the fetch stage. It combines a BHT of saturating counters with a tagged BTB, and generalises the fixed 8-entry / 2-bit / 16-bit predictor in width, depth and counter size. It adds tag-checked hits, a sequential clear engine, a mispredict statistics counter and an optional gshare indexing mode. Lookup is driven by IF; update is driven by the stage that resolves branches.

Parameters:
ENTRIES, 8, number of predictor entries; power of two, ≥2.
PC_W, 16, PC / target width in bits.
CNT_W, 2, saturating counter width in bits; ≥2.
STAT_W, 16, mispredict counter width in bits.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
IF_PC  in  PC_W  fetch PC to look up
hit  out  1  valid entry with matching tag at IF_PC
predict_taken  out  1  hit & counter MSB
predicted_target  out  PC_W  stored target if predict_taken, else IF_PC+2
upd_valid  in  1  a resolved branch is presented this cycle
upd_PC  in  PC_W  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  PC_W  actual branch target
upd_pred_taken  in  1  prediction that was made for this branch at fetch
clear_req  in  1  one-cycle pulse requesting a full invalidate
busy  out  1  clear engine is active
mispredict_cnt  out  STAT_W  saturating count of mispredictions

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- IDX_W = log2(ENTRIES).
  - Index = PC[IDX_W:1] (bit 0 ignored).
  - Tag = PC[PC_W-1:IDX_W+1].
- Storage:
  - valid[] is held in flops with async reset.
  - tag[], counter[] and target[] are reset-less arrays.
- Counter encoding:
  - WT = 1<<(CNT_W-1); WNT = WT-1.
  - Taken when MSB = 1.
- Lookup is combinational, with no bypass. A same-cycle update to the same index is not visible until the next cycle.
- FSM states: CLEAR and IDLE.
  - Reset → CLEAR with clr_idx = 0.
  - CLEAR: each cycle writes entry clr_idx (valid=0, counter=WNT, tag=0, target=0), then clr_idx++.
  - After entry ENTRIES-1 is written → IDLE. A clear therefore takes exactly ENTRIES cycles.
  - IDLE + clear_req → CLEAR with clr_idx = 0. mispredict_cnt is zeroed on the same edge.
  - clear_req while in CLEAR is ignored (no restart).
  - Reset asserted mid-clear → CLEAR, idx 0.
- busy = 1 in CLEAR. In CLEAR:
  - hit = 0, predict_taken = 0, predicted_target = IF_PC+2.
  - upd_valid is ignored: no array write, no statistics update.
- Update in IDLE with upd_valid, entry e at the update index:
  - If valid[e] and tag matches:
    - taken → counter increments, saturating at all-ones.
    - not taken → counter decrements, saturating at 0.
    - taken → target = upd_target; not taken → target unchanged.
  - Otherwise (miss or invalid) the entry is replaced:
    - valid = 1, tag = new tag, target = upd_target.
    - counter = upd_taken ? WT : WNT.
- Statistics: if upd_valid in IDLE and upd_pred_taken != upd_taken, mispredict_cnt increments, saturating at all-ones.
- Simultaneous clear_req and upd_valid in IDLE: clear wins and the update is dropped.
- predicted_target = IF_PC+2 wraps modulo 2^PC_W.
- Reset values: busy = 1; mispredict_cnt = 0; hit = 0; predict_taken = 0; valid[] = 0.

Optional Feature:
GSHARE_INDEX_EN
- Defined:
  - A ghr register, IDX_W bits, resets to 0.
  - Lookup index and update index = PC index XOR ghr.
  - On each IDLE upd_valid: ghr = {ghr[IDX_W-2:0], upd_taken}, applied at the same edge as the array write.
  - ghr is zeroed when entering CLEAR.
  - Tags remain the PC-only tag.
- Undefined: no ghr; index is PC bits only.

Test Plan:
- Reset release, ENTRIES=8 → busy = 1 for exactly 8 cycles, then 0. Lookup of 0x0010 during and after → hit = 0, predicted_target = 0x0012.
- Update (0x0010, taken, target 0x0040) → next cycle lookup 0x0010 gives hit = 1, predict_taken = 1, target 0x0040. Two further taken updates → counter 3, holds at 3. Three not-taken updates → counter 0, predict_taken = 0.
- Aliasing: allocate 0x0010 (taken) then update 0x0110 (not taken, same index 0).
  - Lookup 0x0010 → hit = 0.
  - Lookup 0x0110 → hit = 1, predict_taken = 0.
- Mispredict statistics:
  - 5 updates with upd_pred_taken != upd_taken → mispredict_cnt = 5.
  - Run with STAT_W=3 and 9 mispredicts → saturates at 7.
- clear_req in the same cycle as upd_valid for 0x0020:
  - 8 busy cycles, mispredict_cnt = 0.
  - After the clear, 0x0020 misses.
  - A clear_req pulse at busy cycle 3 does not extend the clear.
- Reset asserted at clear cycle 4 → busy stays 1; clear restarts from index 0 and completes in 8 cycles after release.
- GSHARE_INDEX_EN:
  - Updates (taken) at 0x0002 then 0x0004 → ghr = 2'b11 (ENTRIES=4).
  - Lookup 0x0006 uses index 3^3 = 0.
